// File: rtl/calc2_engine.sv
// calc2_engine: N_PORTS two-cycle request ports share one registered ALU through
// per-port request FIFOs and a round-robin arbiter. Define CALC2_MUL_EN to enable cmd 3 (multiply).
module calc2_engine #(
  parameter int N_PORTS    = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        c_clk,
  input  logic                        reset,
  input  logic [N_PORTS*4-1:0]        req_cmd_in,
  input  logic [N_PORTS*DATA_W-1:0]   req_data_in,
  output logic [N_PORTS-1:0]          req_ready,
  output logic [N_PORTS*DATA_W-1:0]   out_data,
  output logic [N_PORTS*2-1:0]        out_resp
);
  // Capture FSM (one per port)
  //   state    | meaning
  //   CAP_IDLE | waiting for cmd+op1
  //   CAP_OP2  | cmd/op1 latched, FIFO slot reserved; op2 is on the bus now

  localparam int SHW = $clog2(DATA_W);
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int EW  = 4 + 2 * DATA_W;

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_M1 = CW'(FIFO_DEPTH - 1);

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_OP2  = 1'b1
  } cap_state_e;

  cap_state_e          state_q    [N_PORTS];
  cap_state_e          state_d    [N_PORTS];
  logic [3:0]          cmd_q      [N_PORTS];
  logic [3:0]          cmd_d      [N_PORTS];
  logic [DATA_W-1:0]   op1_q      [N_PORTS];
  logic [DATA_W-1:0]   op1_d      [N_PORTS];
  logic [EW-1:0]       mem_q      [N_PORTS][FIFO_DEPTH];
  logic [EW-1:0]       mem_d      [N_PORTS][FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q   [N_PORTS];
  logic [AW-1:0]       wr_ptr_d   [N_PORTS];
  logic [AW-1:0]       rd_ptr_q   [N_PORTS];
  logic [AW-1:0]       rd_ptr_d   [N_PORTS];
  logic [CW-1:0]       count_q    [N_PORTS];
  logic [CW-1:0]       count_d    [N_PORTS];
  logic [DATA_W-1:0]   out_data_q [N_PORTS];
  logic [DATA_W-1:0]   out_data_d [N_PORTS];
  logic [1:0]          out_resp_q [N_PORTS];
  logic [1:0]          out_resp_d [N_PORTS];
  logic [PW-1:0]       rr_q;
  logic [PW-1:0]       rr_d;

  logic [N_PORTS-1:0]  push;
  logic [N_PORTS-1:0]  pop;
  logic                grant_vld;
  logic [PW-1:0]       grant_idx;

  logic [EW-1:0]       entry;
  logic [3:0]          a_cmd;
  logic [DATA_W-1:0]   a_op1;
  logic [DATA_W-1:0]   a_op2;
  logic [DATA_W:0]     sum;
  logic [1:0]          alu_resp;
  logic [DATA_W-1:0]   alu_data;
`ifdef CALC2_MUL_EN
  logic [2*DATA_W-1:0] prod;
`endif

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < N_PORTS; p++) begin
        state_q[p]    <= CAP_IDLE;
        cmd_q[p]      <= '0;
        op1_q[p]      <= '0;
        wr_ptr_q[p]   <= '0;
        rd_ptr_q[p]   <= '0;
        count_q[p]    <= '0;
        out_data_q[p] <= '0;
        out_resp_q[p] <= RESP_NONE;
        for (int e = 0; e < FIFO_DEPTH; e++) begin
          mem_q[p][e] <= '0;
        end
      end
      rr_q <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      op1_q      <= op1_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_data_q <= out_data_d;
      out_resp_q <= out_resp_d;
      rr_q       <= rr_d;
    end
  end

  // A port in CAP_OP2 already owns a slot, so it counts against the free space.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    op1_d     = op1_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    push      = '0;
    pop       = '0;
    req_ready = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      req_ready[p] = (state_q[p] == CAP_OP2) ? (count_q[p] < DEPTH_M1)
                                             : (count_q[p] < DEPTH_C);
      pop[p] = grant_vld && (grant_idx == PW'(p));
      case (state_q[p])
        CAP_IDLE: begin
          if ((req_cmd_in[4*p +: 4] != 4'd0) && req_ready[p]) begin
            cmd_d[p]   = req_cmd_in[4*p +: 4];
            op1_d[p]   = req_data_in[DATA_W*p +: DATA_W];
            state_d[p] = CAP_OP2;
          end
        end
        CAP_OP2: begin
          push[p] = 1'b1;
          mem_d[p][wr_ptr_q[p]] = {cmd_q[p], op1_q[p], req_data_in[DATA_W*p +: DATA_W]};
          wr_ptr_d[p] = wr_ptr_q[p] + AW'(1);
          state_d[p]  = CAP_IDLE;
        end
        default: state_d[p] = CAP_IDLE;
      endcase
      if (pop[p]) begin
        rd_ptr_d[p] = rd_ptr_q[p] + AW'(1);
      end
      count_d[p] = count_q[p] + CW'(push[p]) - CW'(pop[p]);
    end
  end

  // Scan from the farthest offset down so the nearest non-empty port wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int off = N_PORTS - 1; off >= 0; off--) begin
      if (count_q[(int'(rr_q) + off) % N_PORTS] != '0) begin
        grant_vld = 1'b1;
        grant_idx = PW'((int'(rr_q) + off) % N_PORTS);
      end
    end
  end

  always_comb begin
    entry    = mem_q[grant_idx][rd_ptr_q[grant_idx]];
    a_cmd    = entry[EW-1 -: 4];
    a_op1    = entry[2*DATA_W-1 -: DATA_W];
    a_op2    = entry[DATA_W-1:0];
    sum      = {1'b0, a_op1} + {1'b0, a_op2};
    alu_resp = RESP_ERR;
    alu_data = '0;
`ifdef CALC2_MUL_EN
    prod     = {{DATA_W{1'b0}}, a_op1} * {{DATA_W{1'b0}}, a_op2};
`endif
    case (a_cmd)
      4'd1: begin
        if (!sum[DATA_W]) begin
          alu_resp = RESP_OK;
          alu_data = sum[DATA_W-1:0];
        end
      end
      4'd2: begin
        if (a_op2 <= a_op1) begin
          alu_resp = RESP_OK;
          alu_data = a_op1 - a_op2;
        end
      end
`ifdef CALC2_MUL_EN
      4'd3: begin
        if (prod[2*DATA_W-1:DATA_W] == '0) begin
          alu_resp = RESP_OK;
          alu_data = prod[DATA_W-1:0];
        end
      end
`endif
      4'd5: begin
        alu_resp = RESP_OK;
        alu_data = a_op1 << a_op2[SHW-1:0];
      end
      4'd6: begin
        alu_resp = RESP_OK;
        alu_data = a_op1 >> a_op2[SHW-1:0];
      end
      default: begin
        alu_resp = RESP_ERR;
        alu_data = '0;
      end
    endcase
  end

  always_comb begin
    rr_d = rr_q;
    for (int p = 0; p < N_PORTS; p++) begin
      out_resp_d[p] = RESP_NONE;
      out_data_d[p] = '0;
    end
    if (grant_vld) begin
      out_resp_d[grant_idx] = alu_resp;
      out_data_d[grant_idx] = alu_data;
      rr_d = PW'((int'(grant_idx) + 1) % N_PORTS);
    end
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_out
    assign out_data[DATA_W*g +: DATA_W] = out_data_q[g];
    assign out_resp[2*g +: 2]           = out_resp_q[g];
  end

endmodule
